mm_stage_nlane: RTL

Parametrised N-lane memory (MM) pipeline stage for the multi-issue in-order core. It sits between EX and WB.
- Holds one registered entry per lane with valid/allowin handshakes.
- The designated memory lane issues a data-cache request and waits for the response before the stage may advance.
- Adds two things a plain stage register lacks: per-lane branch kill, and a safe cancel path for in-flight cache requests on exception flush.

---
 rtl/mm_stage_nlane_pkg.sv | 21 ++
 rtl/mm_stage_nlane_if.sv | 36 +++
 rtl/mm_stage_nlane_mem_fsm.sv | 73 +++++++
 rtl/mm_stage_nlane.sv | 93 +++++++++
 4 files changed

// File: rtl/mm_stage_nlane_pkg.sv
// Shared definitions for the N-lane MM stage: memory FSM encoding and lane bus geometry.
package mm_stage_nlane_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DONE   = 3'd3,
      ST_CANCEL = 3'd4
   } mm_state_t;

   // Low bit of a lane's slice inside a packed multi-lane bus (lane 0 in the LSBs).
   function automatic int lane_lo(input int lane, input int lane_w);
      return lane * lane_w;
   endfunction

   function automatic int bus_w(input int lanes, input int lane_w);
      return lanes * lane_w;
   endfunction

endpackage

// File: rtl/mm_stage_nlane_if.sv
// Bundle between the MM stage and its neighbours: EX group in, WB group out, data-cache channel.
interface mm_stage_nlane_if
   import mm_stage_nlane_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int LANE_W  = 64,
   parameter int RDATA_W = 32
);
   logic [LANES-1:0]                pre_to_now_valid_i;
   logic                            pre_mem_op_i;
   logic [bus_w(LANES, LANE_W)-1:0] pre_to_ibus;
   logic                            now_allowin_o;
   logic                            next_allowin_i;
   logic [LANES-1:0]                now_to_next_valid_o;
   logic [bus_w(LANES, LANE_W)-1:0] to_next_obus;
   logic [RDATA_W-1:0]              mem_rdata_o;
   logic                            excep_flush_i;
   logic [LANES-1:0]                kill_mask_i;
   logic                            mem_req_o;
   logic                            mem_addr_ok_i;
   logic                            mem_data_ok_i;
   logic [RDATA_W-1:0]              mem_rdata_i;

   modport master (
      output pre_to_now_valid_i, pre_mem_op_i, pre_to_ibus, next_allowin_i,
      output excep_flush_i, kill_mask_i, mem_addr_ok_i, mem_data_ok_i, mem_rdata_i,
      input  now_allowin_o, now_to_next_valid_o, to_next_obus, mem_rdata_o, mem_req_o
   );

   modport slave (
      input  pre_to_now_valid_i, pre_mem_op_i, pre_to_ibus, next_allowin_i,
      input  excep_flush_i, kill_mask_i, mem_addr_ok_i, mem_data_ok_i, mem_rdata_i,
      output now_allowin_o, now_to_next_valid_o, to_next_obus, mem_rdata_o, mem_req_o
   );

endinterface

// File: rtl/mm_stage_nlane_mem_fsm.sv
// Data-cache request control for the memory lane: request, wait, hold result, and drain
// responses of requests abandoned by a flush or kill.
module mm_stage_nlane_mem_fsm
   import mm_stage_nlane_pkg::*;
#(
   parameter int RDATA_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_valid,
   input  logic               load,
   input  logic               load_mop,
   input  logic               leave,
   input  logic               abort,
   input  logic               addr_ok,
   input  logic               data_ok,
   input  logic [RDATA_W-1:0] rdata_in,
   output mm_state_t          state,
   output logic               mem_req,
   output logic [RDATA_W-1:0] rdata_out
);

   mm_state_t          state_reg;
   mm_state_t          state_next;
   logic               capture;
   logic [RDATA_W-1:0] rdata_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (capture) rdata_reg <= rdata_in;
      end
   end

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (load && load_mop) state_next = ST_REQ;
         end
         ST_REQ: begin
            // An accepted request must still see its response, so it goes to CANCEL.
            if (abort)        state_next = addr_ok ? ST_CANCEL : ST_IDLE;
            else if (addr_ok) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (data_ok) begin
               state_next = abort ? ST_IDLE : ST_DONE;
               capture    = ~abort;
            end else if (abort) begin
               state_next = ST_CANCEL;
            end
         end
         ST_DONE: begin
            if (load)                 state_next = load_mop ? ST_REQ : ST_IDLE;
            else if (leave || abort)  state_next = ST_IDLE;
         end
         ST_CANCEL: begin
            if (data_ok) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign state     = state_reg;
   assign mem_req   = (state_reg == ST_REQ) & mem_valid;
   assign rdata_out = rdata_reg;

endmodule

// File: rtl/mm_stage_nlane.sv
// N-lane MM pipeline stage between EX and WB: per-lane entry registers with group handshakes,
// branch kill, and a data-cache access on MEM_LANE that can be cancelled safely on flush.
module mm_stage_nlane
   import mm_stage_nlane_pkg::*;
#(
   parameter int LANES    = 2,
   parameter int LANE_W   = 64,
   parameter int RDATA_W  = 32,
   parameter int MEM_LANE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   mm_stage_nlane_if.slave bus
);

   logic [LANES-1:0]                valid_reg;
   logic [LANES-1:0]                valid_next;
   logic [LANES-1:0]                out_valid;
   logic                            mop_reg;
   logic                            mop_next;
   logic [LANE_W-1:0]               payload_reg [LANES];
   logic [bus_w(LANES, LANE_W)-1:0] obus;

   mm_state_t state;
   logic      ready;
   logic      leave;
   logic      allowin;
   logic      load;
   logic      load_mop;
   logic      abort;

   // The group is ready unless the memory lane still owes a cache result.
   assign ready    = ~(valid_reg[MEM_LANE] & mop_reg) | (state == ST_DONE);
   assign leave    = ready & bus.next_allowin_i;
   assign allowin  = (state != ST_CANCEL) & (~|valid_reg | leave);
   assign load     = allowin & (|bus.pre_to_now_valid_i) & ~bus.excep_flush_i;
   assign load_mop = bus.pre_mem_op_i & bus.pre_to_now_valid_i[MEM_LANE];
   assign abort    = bus.excep_flush_i | bus.kill_mask_i[MEM_LANE];

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign valid_next[gi] = bus.excep_flush_i ? 1'b0 :
                                 load              ? bus.pre_to_now_valid_i[gi] :
                                 leave             ? 1'b0 :
                                 (valid_reg[gi] & ~bus.kill_mask_i[gi]);

         assign out_valid[gi] = valid_reg[gi] & ready & ~bus.excep_flush_i & ~bus.kill_mask_i[gi];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    payload_reg[gi] <= '0;
            else if (load) payload_reg[gi] <= bus.pre_to_ibus[lane_lo(gi, LANE_W) +: LANE_W];
         end

         assign obus[lane_lo(gi, LANE_W) +: LANE_W] = payload_reg[gi];
      end
   endgenerate

   assign mop_next = load ? load_mop : (mop_reg & valid_next[MEM_LANE]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= '0;
         mop_reg   <= 1'b0;
      end else begin
         valid_reg <= valid_next;
         mop_reg   <= mop_next;
      end
   end

   mm_stage_nlane_mem_fsm #(
      .RDATA_W (RDATA_W)
   ) mm_mem_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_valid (valid_reg[MEM_LANE]),
      .load      (load),
      .load_mop  (load_mop),
      .leave     (leave),
      .abort     (abort),
      .addr_ok   (bus.mem_addr_ok_i),
      .data_ok   (bus.mem_data_ok_i),
      .rdata_in  (bus.mem_rdata_i),
      .state     (state),
      .mem_req   (bus.mem_req_o),
      .rdata_out (bus.mem_rdata_o)
   );

   assign bus.now_allowin_o       = allowin;
   assign bus.now_to_next_valid_o = out_valid;
   assign bus.to_next_obus        = obus;

endmodule
